// File: rtl/sram_like_data_slave.sv
// Responder for the MEM-stage SRAM-like data port: word RAM, fixed-latency in-order replies.
// Optional accept stalls from a 16-bit LFSR when SRAM_LIKE_SLAVE_STALL_EN is defined.
module sram_like_data_slave #(
    parameter int DEPTH_LOG2      = 10,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]               mem_q [DEPTH];
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      live_q;
    logic [LATENCY-1:0]        valid_q;
    logic [LATENCY-1:0]        wr_q;
    logic [LATENCY-1:0][31:0]  rdata_q;

    logic                      accept;
    logic                      retire;
    logic                      room;
    logic                      stall;
    logic [DEPTH_LOG2-1:0]     word_idx;
    logic [3:0]                wmask;
    logic [31:0]               bitmask;
    logic                      unused_addr_bits;

    // Upper address bits alias onto the same words.
    assign word_idx         = data_addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^data_addr[31:DEPTH_LOG2+2];

    always_comb begin
        wmask = 4'b1111;
        case (data_size)
            2'd0:    wmask = 4'b0001 << data_addr[1:0];
            2'd1:    wmask = 4'b0011 << {data_addr[1], 1'b0};
            default: wmask = 4'b1111;
        endcase
    end

    assign bitmask = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

`ifdef SRAM_LIKE_SLAVE_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall  = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // A retiring response frees its slot in the same cycle, so a full slave can still accept.
    assign retire       = valid_q[LATENCY-1];
    assign room         = (cnt_q < CW'(MAX_OUTSTANDING)) || retire;
    assign data_addr_ok = rst && live_q && room && !stall;
    assign accept       = data_req && data_addr_ok;

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, retire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // live_q holds off accepts for the first cycle after reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            live_q  <= 1'b0;
            valid_q <= '0;
            wr_q    <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            live_q     <= 1'b1;
            valid_q[0] <= accept;
            wr_q[0]    <= accept && data_wr;
            rdata_q[0] <= (accept && !data_wr) ? mem_q[word_idx] : 32'd0;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                wr_q[i]    <= wr_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
            end
        end
    end

    // RAM contents survive reset; accept is already gated by rst.
    always_ff @(posedge clk) begin
        if (accept && data_wr) begin
            mem_q[word_idx] <= (mem_q[word_idx] & ~bitmask) | (data_wdata & bitmask);
        end
    end

    assign data_data_ok = rst && valid_q[LATENCY-1];
    assign data_rdata   = (rst && valid_q[LATENCY-1] && !wr_q[LATENCY-1]) ? rdata_q[LATENCY-1] : 32'd0;

endmodule

// File: tb/tb_sram_like_data_slave.sv
// Self-checking bench for sram_like_data_slave: two instances (LATENCY 2 and 4) share one stimulus stream
// and are checked every cycle against a transaction-level memory/response model.
module tb_sram_like_data_slave;

    localparam int MAXO = 2;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        aok  [2];
    logic        dok  [2];
    logic [31:0] rdat [2];

    always #5 clk = ~clk;

    sram_like_data_slave #(.DEPTH_LOG2(10), .LATENCY(2), .MAX_OUTSTANDING(2)) dut0 (
        .clk(clk), .rst(rst), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(aok[0]), .data_data_ok(dok[0]), .data_rdata(rdat[0])
    );

    sram_like_data_slave #(.DEPTH_LOG2(10), .LATENCY(4), .MAX_OUTSTANDING(2)) dut1 (
        .clk(clk), .rst(rst), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(aok[1]), .data_data_ok(dok[1]), .data_rdata(rdat[1])
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
    } resp_t;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          edge_cnt = 0;
    bit          ready = 1'b0;
    resp_t       exp_q [2][$];
    logic [31:0] mem_m   [2][1024];
    logic [3:0]  known_m [2][1024];
    resp_t       m_r;
    bit          m_retire;
    bit          m_aok;
    int          m_idx;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s[dut%0d] observed=0x%08h expected=0x%08h", tag, k, obs, exp);
        end
    endtask

    // Byte-granular write into the model: size picks 1/2/4 bytes, aligned down to that size.
    function automatic void apply_write(input int k, input logic [1:0] sz, input logic [31:0] a,
                                        input logic [31:0] wd);
        int nb;
        int base;
        int idx;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base = (int'(a[1:0]) / nb) * nb;
        idx  = int'(a[11:2]);
        for (int b = base; b < base + nb; b++) begin
            mem_m[k][idx][8*b +: 8] = wd[8*b +: 8];
            known_m[k][idx][b]      = 1'b1;
        end
    endfunction

    always @(posedge clk) edge_cnt++;

    // Every cycle: check outputs against the model, then predict what the next edge accepts.
    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            for (int k = 0; k < 2; k++) begin
                if (rst === 1'b0) begin
                    chk("rst_data_ok", k, 32'(dok[k]), 32'd0);
                    chk("rst_rdata", k, rdat[k], 32'd0);
                    chk("rst_addr_ok", k, 32'(aok[k]), 32'd0);
                    exp_q[k].delete();
                end else begin
                    m_retire = (exp_q[k].size() > 0) && (exp_q[k][0].due == edge_cnt);
                    chk("data_ok", k, 32'(dok[k]), 32'(m_retire));
                    if (m_retire && exp_q[k][0].known) chk("rdata", k, rdat[k], exp_q[k][0].data);
                    if (!ready) chk("rdata_after_rst", k, rdat[k], 32'd0);
                    m_aok = ready && ((exp_q[k].size() < MAXO) || m_retire);
                    chk("addr_ok", k, 32'(aok[k]), 32'(m_aok));
                    if (m_retire) void'(exp_q[k].pop_front());
                    if (m_aok && data_req === 1'b1) begin
                        m_idx = int'(data_addr[11:2]);
                        m_r.due = edge_cnt + lat_of(k);
                        if (data_wr) begin
                            apply_write(k, data_size, data_addr, data_wdata);
                            m_r.data  = 32'd0;
                            m_r.known = 1'b1;
                        end else begin
                            m_r.data  = mem_m[k][m_idx];
                            m_r.known = (known_m[k][m_idx] == 4'hF);
                        end
                        exp_q[k].push_back(m_r);
                    end
                end
            end
            ready = (rst === 1'b1);
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted on dut0.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int n;
        data_req   = 1'b1;
        data_wr    = wr;
        data_size  = sz;
        data_addr  = a;
        data_wdata = wd;
        n = 0;
        @(negedge clk);
        while (aok[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_accept", 0, 32'(aok[0]), 32'd1);
        @(posedge clk);
        #1;
        data_req = 1'b0;
    endtask

    // dut0 has LATENCY 2: the read response shows on the second falling edge after accept.
    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, 2'd2, a, 32'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_ok"}, 0, 32'(dok[0]), 32'd1);
        chk(tag, 0, rdat[0], exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) begin
                known_m[k][i] = 4'h0;
                mem_m[k][i]   = 32'd0;
            end
        end
        rst        = 1'b0;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_size  = 2'd2;
        data_addr  = 32'd0;
        data_wdata = 32'd0;

        // Reset held 3 cycles with a pending request, then one quiet cycle after release.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 data_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Word write followed immediately by a read of the same word.
        issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        read_check("rd_word", 32'h100, 32'hDEADBEEF);

        // Byte and halfword merges into an existing word.
        issue(1'b1, 2'd2, 32'h40, 32'h11223344);
        issue(1'b1, 2'd0, 32'h41, 32'h0000AA00);
        issue(1'b1, 2'd1, 32'h42, 32'hBEEF0000);
        read_check("rd_merge", 32'h40, 32'hBEEFAA44);

        // Address wrap-around past the RAM depth.
        issue(1'b1, 2'd2, 32'h1000, 32'h5A5A5A5A);
        read_check("rd_wrap", 32'h0, 32'h5A5A5A5A);

        // Reset with two reads in flight: neither may answer, the earlier write persists.
        issue(1'b1, 2'd2, 32'h300, 32'hCAFEF00D);
        issue(1'b0, 2'd2, 32'h300, 32'd0);
        issue(1'b0, 2'd2, 32'h304, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_resp_after_rst", 0, 32'(dok[0]), 32'd0);
            chk("no_resp_after_rst", 1, 32'(dok[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        read_check("rd_after_rst", 32'h300, 32'hCAFEF00D);

        // Held request: dut1 (LATENCY 4, 2 outstanding) accepts 2, stalls 2, repeats; dut0 never stalls.
        repeat (10) @(posedge clk);
        #1;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h100;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("throttle_aok", 1, 32'(aok[1]), 32'((c % 4) < 2));
            chk("b2b_aok", 0, 32'(aok[0]), 32'd1);
        end
        @(posedge clk);
        #1 data_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Random traffic over a 16-word window.
        for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 32'h200 + 32'(4 * i), $urandom);
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  32'h200 + 32'($urandom_range(0, 63)), $urandom);
        end
        repeat (10) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
